exec_muldiv: RTL and testbench

Iterative RV M-extension multiply/divide unit attached to the execute stage. It accepts one operation at a time from the decode/execute boundary, computes it over multiple cycles, and returns the result and destination register with a one-cycle `done` pulse. While `busy` is high, the execute stage stalls the pipeline. The datapath width is set by `XLEN`, and RV64 word (`*W`) operations are optional.

---
 rtl/exec_muldiv.sv | 244 ++++++++++++++++++++++++
 tb/tb_exec_muldiv.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/exec_muldiv.sv
// Iterative RV M-extension multiply/divide unit for the execute stage.
// Multiply is radix-2 shift-add, divide is restoring; both work on operand
// magnitudes and the sign is restored on the edge that enters DONE.
// Build option: define EXEC_MULDIV_WORD_EN (with XLEN = 64) to implement the
// RV64 *W operations; otherwise is_word is ignored.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; fast-path cases resolve straight to DONE
// CALC  | one multiply/divide iteration per cycle, K = XLEN or 32
// DONE  | done pulse, result/rd_out valid; always returns to IDLE
module exec_muldiv #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic            is_word,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int W2 = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [6:0] K_FULL_LAST = 7'(XLEN - 1);
    localparam logic [6:0] K_WORD_LAST = 7'd31;

    function automatic logic [XLEN-1:0] ext32(input logic [31:0] x, input logic sgn);
        logic [XLEN-1:0] r;
        r = {XLEN{sgn & x[31]}};
        r[31:0] = x;
        return r;
    endfunction

    logic word_in;
`ifdef EXEC_MULDIV_WORD_EN
    assign word_in = is_word && (XLEN == 64);
`else
    logic unused_is_word;
    assign unused_is_word = is_word;
    assign word_in = 1'b0;
`endif

    logic [1:0]      state_q, state_d;
    logic [6:0]      cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic            word_q, word_d;
    logic            neg_q, neg_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic [W2-1:0]   opa_q, opa_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_q, rd_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign rd_out = rd_q;

    // Operand conditioning and fast-path detection for an incoming request
    logic            sgn1_in, sgn2_in, a_neg, b_neg;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
    logic            div_zero, ovf, illegal, fast_in, neg_in;
    logic [XLEN-1:0] fast_raw, fast_res;
    always_comb begin
        sgn1_in = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
        sgn2_in = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
        if (word_in) begin
            a_ext = ext32(rs1_data[31:0], sgn1_in);
            b_ext = ext32(rs2_data[31:0], sgn2_in);
        end else begin
            a_ext = rs1_data;
            b_ext = rs2_data;
        end
        a_neg = sgn1_in && a_ext[XLEN-1];
        b_neg = sgn2_in && b_ext[XLEN-1];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;
        // remainder follows the dividend; products and quotients use rs1^rs2
        neg_in = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = funct3[2] && (b_ext == '0);
        if (word_in)
            ovf = funct3[2] && !funct3[0] &&
                  (rs1_data[31:0] == 32'h8000_0000) && (rs2_data[31:0] == 32'hFFFF_FFFF);
        else
            ovf = funct3[2] && !funct3[0] && (rs1_data == MIN_NEG) && (rs2_data == '1);
        illegal = word_in && !funct3[2] && (funct3[1:0] != 2'b00);
        fast_in = div_zero || ovf || illegal;
        if (illegal)
            fast_raw = '0;
        else if (div_zero)
            fast_raw = funct3[1] ? a_ext : '1;
        else
            fast_raw = funct3[1] ? '0 : a_ext;
        fast_res = word_q_unused_guard(fast_raw);
    end

    function automatic logic [XLEN-1:0] word_q_unused_guard(input logic [XLEN-1:0] x);
        return word_in ? ext32(x[31:0], 1'b1) : x;
    endfunction

    // One iteration: shift-add multiply step or restoring divide step
    logic [XLEN:0]   rem_sh;
    logic            rem_ge;
    logic [XLEN-1:0] rem_new;
    logic [W2-1:0]   acc_it, opa_it;
    logic [XLEN-1:0] opb_it;
    always_comb begin
        rem_sh  = {acc_q[XLEN-1:0], opb_q[XLEN-1]};
        rem_ge  = rem_sh >= {1'b0, opa_q[XLEN-1:0]};
        rem_new = rem_ge ? (rem_sh[XLEN-1:0] - opa_q[XLEN-1:0]) : rem_sh[XLEN-1:0];
        if (f3_q[2]) begin
            acc_it = {{XLEN{1'b0}}, rem_new};
            opa_it = opa_q;
            opb_it = {opb_q[XLEN-2:0], rem_ge};
        end else begin
            acc_it = opb_q[0] ? (acc_q + opa_q) : acc_q;
            opa_it = opa_q << 1;
            opb_it = opb_q >> 1;
        end
    end

    // Sign fix-up and result select applied to the final iteration's output
    logic [W2-1:0]   prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix, res_raw, res_fin;
    always_comb begin
        prod_fix = neg_q ? -acc_it : acc_it;
        quo_fix  = neg_q ? -opb_it : opb_it;
        rem_fix  = neg_q ? -acc_it[XLEN-1:0] : acc_it[XLEN-1:0];
        if (!f3_q[2])
            res_raw = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[W2-1:XLEN];
        else
            res_raw = f3_q[1] ? rem_fix : quo_fix;
        res_fin = word_q ? ext32(res_raw[31:0], 1'b1) : res_raw;
    end

    // Next-state, operand load and result capture
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        word_d   = word_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        rd_d     = rd_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    f3_d   = funct3;
                    word_d = word_in;
                    neg_d  = neg_in;
                    rd_d   = rd_in;
                    cnt_d  = '0;
                    if (fast_in) begin
                        state_d  = S_DONE;
                        result_d = fast_res;
                        done_d   = 1'b1;
                    end else begin
                        state_d = S_CALC;
                        acc_d   = '0;
                        if (funct3[2]) begin
                            opa_d = {{XLEN{1'b0}}, b_mag};
                            opb_d = word_in ? (a_mag << (XLEN - 32)) : a_mag;
                        end else begin
                            opa_d = {{XLEN{1'b0}}, a_mag};
                            opb_d = b_mag;
                        end
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = acc_it;
                    opa_d = opa_it;
                    opb_d = opb_it;
                    cnt_d = cnt_q + 7'd1;
                    if (cnt_q == (word_q ? K_WORD_LAST : K_FULL_LAST)) begin
                        state_d  = S_DONE;
                        cnt_d    = '0;
                        result_d = res_fin;
                        done_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            rd_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            word_q   <= word_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_exec_muldiv.sv
// Scoreboard bench for exec_muldiv at XLEN = 64. Stimulus pushes the
// hand-computed result, rd and due cycle; a monitor pops on every done.
module tb_exec_muldiv;
    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic        is_word = 1'b0;
    logic [63:0] rs1_data = '0;
    logic [63:0] rs2_data = '0;
    logic [4:0]  rd_in = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [63:0] result;
    logic [4:0]  rd_out;

    exec_muldiv #(.XLEN(64)) dut (
        .clk(clk), .resetn(resetn), .start(start), .funct3(funct3), .is_word(is_word),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in), .flush(flush),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        int          due;
        int          id;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          op_id = 0;
    logic [63:0] last_res = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (resetn && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk($sformatf("op%0d_result", mon_e.id), result, mon_e.res);
                chk($sformatf("op%0d_rd", mon_e.id), 64'(rd_out), 64'(mon_e.rd));
                chk($sformatf("op%0d_done_cycle", mon_e.id), 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    task automatic kick(input logic [2:0] f3, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, output int c0);
        @(negedge clk);
        funct3 = f3; is_word = w; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
        c0 = cyc;
    endtask

    task automatic expect_op(input logic [63:0] res, input logic [4:0] rd, input int due);
        exp_t e;
        e.res = res; e.rd = rd; e.due = due; e.id = op_id;
        op_id++;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done in 200 cycles expected done", nm);
            sb.delete();
        end
        @(negedge clk);
        chk({nm, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd,
                          input logic [63:0] exp, input int lat);
        int c0;
        kick(f3, w, a, b, rd, c0);
        expect_op(exp, rd, c0 + lat);
        @(negedge clk);
        start = 1'b0;
        wait_done($sformatf("op%0d", op_id - 1));
        last_res = exp;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish by 400000");
        $fatal(1);
    end

    initial begin
        int c0;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_rd", 64'(rd_out), 64'd0);
        resetn = 1'b1;

        run_op(F_MUL,    0, 64'd7, -64'sd3, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 65);
        run_op(F_MULHU,  0, ONES, ONES, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run_op(F_MULHSU, 0, ONES, 64'd2, 5'd7, ONES, 65);
        run_op(F_MULH,   0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd8,
               64'h4000_0000_0000_0000, 65);
        run_op(F_MUL,    0, 64'h1_0000_0001, 64'h1_0000_0001, 5'd9, 64'h0000_0002_0000_0001, 65);
        run_op(F_DIV,    0, -64'sd7, 64'd2, 5'd10, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run_op(F_REM,    0, -64'sd7, 64'd2, 5'd11, ONES, 65);
        run_op(F_DIV,    0, 64'd7, -64'sd2, 5'd12, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run_op(F_REM,    0, 64'd7, -64'sd2, 5'd13, 64'd1, 65);
        run_op(F_DIVU,   0, 64'd100, 64'd7, 5'd14, 64'd14, 65);
        run_op(F_REMU,   0, 64'd100, 64'd7, 5'd15, 64'd2, 65);
        run_op(F_DIVU,   0, 64'd12345, 64'd0, 5'd16, ONES, 1);
        run_op(F_REM,    0, -64'sd7, 64'd0, 5'd17, 64'hFFFF_FFFF_FFFF_FFF9, 1);
        run_op(F_DIV,    0, 64'h8000_0000_0000_0000, ONES, 5'd18, 64'h8000_0000_0000_0000, 1);
        run_op(F_REM,    0, 64'h8000_0000_0000_0000, ONES, 5'd19, 64'd0, 1);
`ifdef EXEC_MULDIV_WORD_EN
        run_op(F_DIV,    1, 64'h1_8000_0000, 64'd1, 5'd20, 64'hFFFF_FFFF_8000_0000, 33);
        run_op(F_MULHU,  1, ONES, ONES, 5'd21, 64'd0, 1);
        run_op(F_MUL,    1, 64'h7FFF_FFFF, 64'd2, 5'd22, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        run_op(F_DIVU,   1, 64'hFFFF_FFFF_FFFF_FFF9, 64'h1_0000_0000, 5'd23, ONES, 1);
        run_op(F_REMU,   1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd16, 5'd24, 64'd9, 33);
`else
        run_op(F_DIV,    1, 64'h1_8000_0000, 64'd1, 5'd20, 64'h1_8000_0000, 65);
        run_op(F_MULHU,  1, ONES, ONES, 5'd21, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run_op(F_MUL,    1, 64'h7FFF_FFFF, 64'd2, 5'd22, 64'h0000_0000_FFFF_FFFE, 65);
        run_op(F_DIVU,   1, 64'hFFFF_FFFF_FFFF_FFF9, 64'h1_0000_0000, 5'd23, 64'hFFFF_FFFF, 65);
        run_op(F_REMU,   1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd16, 5'd24, 64'd9, 65);
`endif

        // start while CALC is ignored: only the first op completes, on time
        kick(F_DIVU, 0, 64'd1000, 64'd10, 5'd25, c0);
        expect_op(64'd100, 5'd25, c0 + 65);
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 5) @(negedge clk);
        funct3 = F_MUL; rs1_data = 64'd3; rs2_data = 64'd3; rd_in = 5'd26; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start");
        last_res = 64'd100;

        // start held through the DONE cycle of a fast op is ignored
        kick(F_DIVU, 0, 64'd5, 64'd0, 5'd27, c0);
        expect_op(ONES, 5'd27, c0 + 1);
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_ignored", 64'(busy), 64'd0);
        last_res = ONES;

        // flush in cycle 10 of a DIV: no done, result untouched
        kick(F_DIV, 0, -64'sd7, 64'd2, 5'd28, c0);
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_done", 64'(done), 64'd0);
        chk("flush_result", result, last_res);
        repeat (70) @(negedge clk);
        chk("flush_result_later", result, last_res);

        // flush beats start in IDLE
        @(negedge clk);
        funct3 = F_MUL; rs1_data = 64'd2; rs2_data = 64'd2; rd_in = 5'd29;
        start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_beats_start", 64'(busy), 64'd0);

        // reset mid-CALC clears every output, no done for the aborted op
        kick(F_MUL, 0, 64'd7, -64'sd3, 5'd30, c0);
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 20) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_done", 64'(done), 64'd0);
        chk("midreset_result", result, 64'd0);
        chk("midreset_rd", 64'(rd_out), 64'd0);
        resetn = 1'b1;
        repeat (70) @(negedge clk);

        run_op(F_MUL, 0, 64'd6, 64'd7, 5'd31, 64'd42, 65);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
